// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: FSM encodings, the divisor
// floor and the parity helper used by both RX and TX paths.
package uart_pkg;

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

   localparam int MIN_DIV = 4;

   // Parity bit that makes the total number of ones even (odd=0) or odd (odd=1).
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_fifo_p.sv
// Show-ahead synchronous FIFO; the head word is visible on rdata while not empty.
// Drops pushes when full (unless popping in the same cycle) and flags misuse as 1-cycle pulses.
module uart_fifo_p #(
   parameter int W  = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overrun,
   output logic          underrun
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          empty;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overrun  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
         overrun  <= push && !do_push;
         underrun <= pop && empty;
      end
   end

endmodule

// File: rtl/uart_if_p.sv
// Full-duplex UART with run-time divisor, optional parity, 1/2 stop bits,
// byte FIFOs in both directions and sticky receive error flags.
module uart_if_p #(
   parameter int DIV_W   = 16,
   parameter int FIFO_AW = 3,
   parameter int DATA_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DIV_W-1:0]   baud_div,
   input  logic               parity_en,
   input  logic               parity_odd,
   input  logic               two_stop,
   input  logic               rx,
   output logic               tx,
   input  logic               rx_rden,
   output logic [DATA_W-1:0]  rx_rdata,
   output logic               rx_fifo_dvalid,
   output logic               rx_fifo_full,
   output logic [FIFO_AW:0]   rx_fifo_count,
   input  logic [DATA_W-1:0]  tx_wdata,
   input  logic               tx_wten,
   output logic               tx_fifo_full,
   output logic               tx_busy,
   input  logic               err_clr,
   output logic               rx_par_err,
   output logic               rx_frm_err,
   output logic               rx_overrun,
   output logic               rx_underrun,
   output logic               tx_overrun
);

   import uart_pkg::*;

   logic [DIV_W-1:0] div_eff;
   assign div_eff = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;

   // Synchroniser plus four history taps; the newest synced sample is the fifth tap.
   logic       rx_meta, rx_sync, rx_bit, rx_fall;
   logic [3:0] rx_hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_hist <= '1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_hist <= {rx_hist[2:0], rx_sync};
      end
   end

   assign rx_bit  = ($countones({rx_hist, rx_sync}) >= 3);
   assign rx_fall = rx_hist[0] & ~rx_sync;

   rx_state_t         rx_state, rx_state_n;
   logic [DIV_W-1:0]  rx_cnt, rx_cnt_n, rx_div, rx_div_n;
   logic [3:0]        rx_nbit, rx_nbit_n;
   logic [DATA_W-1:0] rx_shift, rx_shift_n;
   logic              rx_pen, rx_pen_n, rx_podd, rx_podd_n, rx_pbad, rx_pbad_n;
   logic              rx_tick, rx_push, par_set, frm_set, rx_ovr_p;

   assign rx_tick = (rx_cnt == DIV_W'(1));

   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_div_n   = rx_div;
      rx_nbit_n  = rx_nbit;
      rx_shift_n = rx_shift;
      rx_pen_n   = rx_pen;
      rx_podd_n  = rx_podd;
      rx_pbad_n  = rx_pbad;
      rx_push    = 1'b0;
      par_set    = 1'b0;
      frm_set    = 1'b0;
      if (rx_state != RX_IDLE) rx_cnt_n = rx_tick ? rx_div : rx_cnt - 1'b1;
      case (rx_state)
         RX_IDLE: begin
            if (rx_fall) begin
               rx_div_n   = div_eff;
               rx_cnt_n   = div_eff >> 1;
               rx_pen_n   = parity_en;
               rx_podd_n  = parity_odd;
               rx_state_n = RX_START;
            end
         end
         RX_START: begin
            if (rx_tick) begin
               if (rx_bit) begin
                  rx_state_n = RX_IDLE;
               end else begin
                  rx_state_n = RX_DATA;
                  rx_nbit_n  = '0;
                  rx_pbad_n  = 1'b0;
               end
            end
         end
         RX_DATA: begin
            if (rx_tick) begin
               rx_shift_n = {rx_bit, rx_shift[DATA_W-1:1]};
               if (rx_nbit == 4'(DATA_W-1)) rx_state_n = rx_pen ? RX_PAR : RX_STOP;
               else                         rx_nbit_n  = rx_nbit + 1'b1;
            end
         end
         RX_PAR: begin
            if (rx_tick) begin
               rx_pbad_n  = (rx_bit != parity_bit(8'(rx_shift), rx_podd));
               rx_state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_tick) begin
               rx_state_n = RX_IDLE;
               if (rx_bit) begin
                  rx_push = 1'b1;
                  par_set = rx_pbad;
               end else begin
                  frm_set = 1'b1;
               end
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_div   <= '0;
         rx_nbit  <= '0;
         rx_shift <= '0;
         rx_pen   <= 1'b0;
         rx_podd  <= 1'b0;
         rx_pbad  <= 1'b0;
      end else begin
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_div   <= rx_div_n;
         rx_nbit  <= rx_nbit_n;
         rx_shift <= rx_shift_n;
         rx_pen   <= rx_pen_n;
         rx_podd  <= rx_podd_n;
         rx_pbad  <= rx_pbad_n;
      end
   end

   uart_fifo_p #(.W(DATA_W), .AW(FIFO_AW)) u_rx_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (rx_push),
      .wdata    (rx_shift),
      .pop      (rx_rden),
      .rdata    (rx_rdata),
      .full     (rx_fifo_full),
      .count    (rx_fifo_count),
      .overrun  (rx_ovr_p),
      .underrun (rx_underrun)
   );

   assign rx_fifo_dvalid = (rx_fifo_count != '0);

   // A clear in the same cycle as a new error wins and the error is lost.
   always_ff @(posedge clk) begin
      if (rst || err_clr) begin
         rx_par_err <= 1'b0;
         rx_frm_err <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         if (par_set)  rx_par_err <= 1'b1;
         if (frm_set)  rx_frm_err <= 1'b1;
         if (rx_ovr_p) rx_overrun <= 1'b1;
      end
   end

   tx_state_t         tx_state, tx_state_n;
   logic [DIV_W-1:0]  tx_cnt, tx_cnt_n, tx_div, tx_div_n;
   logic [3:0]        tx_nbit, tx_nbit_n;
   logic [DATA_W-1:0] tx_shift, tx_shift_n, tx_head;
   logic              tx_pen, tx_pen_n, tx_par, tx_par_n, tx_two, tx_two_n;
   logic              tx_stop2, tx_stop2_n, tx_q, tx_q_n;
   logic              tx_tick, tx_pop, tx_start, tx_avail;
   logic [FIFO_AW:0]  tx_count;
   logic              tx_underrun_unused;

   assign tx_tick  = (tx_cnt == DIV_W'(1));
   assign tx_avail = (tx_count != '0);

   // The final stop bit chains straight into the next start bit when data is waiting.
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_div_n   = tx_div;
      tx_nbit_n  = tx_nbit;
      tx_shift_n = tx_shift;
      tx_pen_n   = tx_pen;
      tx_par_n   = tx_par;
      tx_two_n   = tx_two;
      tx_stop2_n = tx_stop2;
      tx_q_n     = tx_q;
      tx_pop     = 1'b0;
      tx_start   = 1'b0;
      if (tx_state != TX_IDLE) tx_cnt_n = tx_tick ? tx_div : tx_cnt - 1'b1;
      case (tx_state)
         TX_IDLE: tx_start = tx_avail;
         TX_START: begin
            if (tx_tick) begin
               tx_q_n     = tx_shift[0];
               tx_shift_n = tx_shift >> 1;
               tx_nbit_n  = '0;
               tx_state_n = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_tick) begin
               if (tx_nbit == 4'(DATA_W-1)) begin
                  tx_stop2_n = 1'b0;
                  tx_q_n     = tx_pen ? tx_par : 1'b1;
                  tx_state_n = tx_pen ? TX_PAR : TX_STOP;
               end else begin
                  tx_q_n     = tx_shift[0];
                  tx_shift_n = tx_shift >> 1;
                  tx_nbit_n  = tx_nbit + 1'b1;
               end
            end
         end
         TX_PAR: begin
            if (tx_tick) begin
               tx_q_n     = 1'b1;
               tx_stop2_n = 1'b0;
               tx_state_n = TX_STOP;
            end
         end
         TX_STOP: begin
            if (tx_tick) begin
               if (tx_two && !tx_stop2) tx_stop2_n = 1'b1;
               else if (tx_avail)       tx_start   = 1'b1;
               else                     tx_state_n = TX_IDLE;
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase
      if (tx_start) begin
         tx_pop     = 1'b1;
         tx_shift_n = tx_head;
         tx_div_n   = div_eff;
         tx_cnt_n   = div_eff;
         tx_pen_n   = parity_en;
         tx_par_n   = parity_bit(8'(tx_head), parity_odd);
         tx_two_n   = two_stop;
         tx_q_n     = 1'b0;
         tx_state_n = TX_START;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_div   <= '0;
         tx_nbit  <= '0;
         tx_shift <= '0;
         tx_pen   <= 1'b0;
         tx_par   <= 1'b0;
         tx_two   <= 1'b0;
         tx_stop2 <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_div   <= tx_div_n;
         tx_nbit  <= tx_nbit_n;
         tx_shift <= tx_shift_n;
         tx_pen   <= tx_pen_n;
         tx_par   <= tx_par_n;
         tx_two   <= tx_two_n;
         tx_stop2 <= tx_stop2_n;
         tx_q     <= tx_q_n;
      end
   end

   uart_fifo_p #(.W(DATA_W), .AW(FIFO_AW)) u_tx_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (tx_wten),
      .wdata    (tx_wdata),
      .pop      (tx_pop),
      .rdata    (tx_head),
      .full     (tx_fifo_full),
      .count    (tx_count),
      .overrun  (tx_overrun),
      .underrun (tx_underrun_unused)
   );

   assign tx      = tx_q;
   assign tx_busy = (tx_state != TX_IDLE) || tx_avail;

endmodule

// File: tb/tb_uart_if_p.sv
// Self-checking bench for uart_if_p: random loopback frames checked bit-by-bit
// against a frame model, plus injected error frames and FIFO boundary cases.
module tb_uart_if_p;

   localparam int DIV_W   = 16;
   localparam int FIFO_AW = 3;
   localparam int DATA_W  = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [DIV_W-1:0]   baud_div;
   logic               parity_en, parity_odd, two_stop;
   logic               rx, tx, rx_drv, loop_en;
   logic               rx_rden;
   logic [DATA_W-1:0]  rx_rdata;
   logic               rx_fifo_dvalid, rx_fifo_full;
   logic [FIFO_AW:0]   rx_fifo_count;
   logic [DATA_W-1:0]  tx_wdata;
   logic               tx_wten, tx_fifo_full, tx_busy, err_clr;
   logic               rx_par_err, rx_frm_err, rx_overrun, rx_underrun, tx_overrun;

   int vec_count   = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign rx = loop_en ? tx : rx_drv;

   uart_if_p #(.DIV_W(DIV_W), .FIFO_AW(FIFO_AW), .DATA_W(DATA_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .baud_div       (baud_div),
      .parity_en      (parity_en),
      .parity_odd     (parity_odd),
      .two_stop       (two_stop),
      .rx             (rx),
      .tx             (tx),
      .rx_rden        (rx_rden),
      .rx_rdata       (rx_rdata),
      .rx_fifo_dvalid (rx_fifo_dvalid),
      .rx_fifo_full   (rx_fifo_full),
      .rx_fifo_count  (rx_fifo_count),
      .tx_wdata       (tx_wdata),
      .tx_wten        (tx_wten),
      .tx_fifo_full   (tx_fifo_full),
      .tx_busy        (tx_busy),
      .err_clr        (err_clr),
      .rx_par_err     (rx_par_err),
      .rx_frm_err     (rx_frm_err),
      .rx_overrun     (rx_overrun),
      .rx_underrun    (rx_underrun),
      .tx_overrun     (tx_overrun)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Frame model: start 0, data LSB first, optional parity, one or two stop bits of 1.
   function automatic void buildFrame(input logic [7:0] d, input logic pen, input logic podd,
                                      input logic two, output logic [15:0] bits, output int n);
      n    = 0;
      bits = '0;
      bits[n] = 1'b0;
      n++;
      for (int i = 0; i < 8; i++) begin
         bits[n] = ((d >> i) & 8'd1) != 0;
         n++;
      end
      if (pen) begin
         bits[n] = (($countones(d) + int'(podd)) % 2) == 1;
         n++;
      end
      bits[n] = 1'b1;
      n++;
      if (two) begin
         bits[n] = 1'b1;
         n++;
      end
   endfunction

   function automatic int effDiv(input int d);
      return (d < 4) ? 4 : d;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] d);
      tx_wdata = d;
      tx_wten  = 1'b1;
      tick(1);
      tx_wten  = 1'b0;
   endtask

   // Waits for the start bit and checks the first and last clock of every bit.
   task automatic checkTxFrame(input logic [7:0] d, input logic pen, input logic podd,
                               input logic two, input int div, input bit last);
      logic [15:0] bits;
      int          n;
      int          waited;
      int          de;
      de = effDiv(div);
      buildFrame(d, pen, podd, two, bits, n);
      waited = 0;
      while (tx !== 1'b0 && waited < 400) begin
         tick(1);
         waited++;
      end
      if (tx !== 1'b0) begin
         checkOutput("tx_start_timeout", 32'(tx), 32'(0));
         return;
      end
      for (int k = 0; k < n; k++) begin
         checkOutput($sformatf("tx_%02h_bit%0d_first", d, k), 32'(tx), 32'(bits[k]));
         if (k == 4) checkOutput("tx_busy_mid", 32'(tx_busy), 32'(1));
         tick(de - 1);
         checkOutput($sformatf("tx_%02h_bit%0d_last", d, k), 32'(tx), 32'(bits[k]));
         tick(1);
      end
      if (last) begin
         checkOutput("tx_idle_after", 32'(tx), 32'(1));
         checkOutput("tx_busy_after", 32'(tx_busy), 32'(0));
      end
   endtask

   task automatic sendRxFrame(input logic [7:0] d, input logic pen, input logic podd,
                              input logic flip_par, input logic stop_val, input int div);
      logic [15:0] bits;
      int          n;
      buildFrame(d, pen, podd, 1'b0, bits, n);
      if (pen && flip_par) bits[9] = ~bits[9];
      bits[n-1] = stop_val;
      for (int k = 0; k < n; k++) begin
         rx_drv = bits[k];
         tick(div);
      end
      rx_drv = 1'b1;
      tick(div);
   endtask

   task automatic checkRxPop(input string tag, input logic [7:0] exp);
      checkOutput({tag, "_dvalid"}, 32'(rx_fifo_dvalid), 32'(1));
      checkOutput({tag, "_data"}, 32'(rx_rdata), 32'(exp));
      rx_rden = 1'b1;
      tick(1);
      rx_rden = 1'b0;
   endtask

   task automatic pulseErrClr();
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] q[$];
      logic [7:0] b;
      logic [7:0] sent[9];
      logic       pen, podd, two;
      int         div;
      int         ovr_seen;

      rst = 1'b1; baud_div = 16'd20; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
      rx_drv = 1'b1; loop_en = 1'b0; rx_rden = 1'b0; tx_wdata = '0; tx_wten = 1'b0; err_clr = 1'b0;
      tick(3);
      rst = 1'b0;

      checkOutput("rst_tx", 32'(tx), 32'(1));
      checkOutput("rst_tx_busy", 32'(tx_busy), 32'(0));
      checkOutput("rst_rx_count", 32'(rx_fifo_count), 32'(0));
      checkOutput("rst_rx_dvalid", 32'(rx_fifo_dvalid), 32'(0));
      checkOutput("rst_rx_full", 32'(rx_fifo_full), 32'(0));
      checkOutput("rst_rx_rdata", 32'(rx_rdata), 32'(0));
      checkOutput("rst_tx_full", 32'(tx_fifo_full), 32'(0));
      checkOutput("rst_errs", 32'({rx_par_err, rx_frm_err, rx_overrun, rx_underrun, tx_overrun}), 32'(0));

      $display("[TB] 8N1 0x55 at divisor 20");
      fork
         applyStimulus(8'h55);
         checkTxFrame(8'h55, 1'b0, 1'b0, 1'b0, 20, 1'b1);
      join

      $display("[TB] loopback odd parity, chained frames");
      loop_en = 1'b1; baud_div = 16'd10; parity_en = 1'b1; parity_odd = 1'b1;
      fork
         begin
            applyStimulus(8'h00);
            applyStimulus(8'hFF);
            applyStimulus(8'hA5);
         end
         begin
            checkTxFrame(8'h00, 1'b1, 1'b1, 1'b0, 10, 1'b0);
            checkTxFrame(8'hFF, 1'b1, 1'b1, 1'b0, 10, 1'b0);
            checkTxFrame(8'hA5, 1'b1, 1'b1, 1'b0, 10, 1'b1);
         end
      join
      tick(20);
      checkOutput("loop_count", 32'(rx_fifo_count), 32'(3));
      checkOutput("loop_errs", 32'({rx_par_err, rx_frm_err, rx_overrun}), 32'(0));
      checkRxPop("loop0", 8'h00);
      checkRxPop("loop1", 8'hFF);
      checkRxPop("loop2", 8'hA5);

      $display("[TB] random loopback frames");
      for (int i = 0; i < 10; i++) begin
         div  = $urandom_range(1, 12);
         pen  = 1'($urandom_range(0, 1));
         podd = 1'($urandom_range(0, 1));
         two  = 1'($urandom_range(0, 1));
         b    = 8'($urandom);
         baud_div = 16'(div); parity_en = pen; parity_odd = podd; two_stop = two;
         fork
            applyStimulus(b);
            checkTxFrame(b, pen, podd, two, div, 1'b1);
         join
         tick(12);
         checkOutput($sformatf("rand%0d_count", i), 32'(rx_fifo_count), 32'(1));
         checkOutput($sformatf("rand%0d_errs", i), 32'({rx_par_err, rx_frm_err, rx_overrun}), 32'(0));
         checkRxPop($sformatf("rand%0d", i), b);
      end

      $display("[TB] injected parity error");
      loop_en = 1'b0; rx_drv = 1'b1; baud_div = 16'd16; parity_en = 1'b1; parity_odd = 1'b1; two_stop = 1'b0;
      tick(5);
      sendRxFrame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 16);
      checkOutput("par_count", 32'(rx_fifo_count), 32'(1));
      checkOutput("par_err_set", 32'(rx_par_err), 32'(1));
      checkOutput("par_frm_clear", 32'(rx_frm_err), 32'(0));
      pulseErrClr();
      checkOutput("par_err_cleared", 32'(rx_par_err), 32'(0));
      checkRxPop("par", 8'hA5);

      $display("[TB] injected framing error");
      sendRxFrame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 16);
      checkOutput("frm_count", 32'(rx_fifo_count), 32'(0));
      checkOutput("frm_err_set", 32'(rx_frm_err), 32'(1));
      checkOutput("frm_par_clear", 32'(rx_par_err), 32'(0));
      pulseErrClr();
      checkOutput("frm_err_cleared", 32'(rx_frm_err), 32'(0));

      $display("[TB] one-clock glitch on idle line");
      rx_drv = 1'b0;
      tick(1);
      rx_drv = 1'b1;
      tick(40);
      checkOutput("glitch_count", 32'(rx_fifo_count), 32'(0));
      checkOutput("glitch_errs", 32'({rx_par_err, rx_frm_err, rx_overrun}), 32'(0));
      b = 8'($urandom);
      sendRxFrame(b, 1'b1, 1'b1, 1'b0, 1'b1, 16);
      checkRxPop("post_glitch", b);

      $display("[TB] RX FIFO overrun and underrun");
      parity_en = 1'b0; baud_div = 16'd8;
      q.delete();
      for (int i = 0; i < 9; i++) begin
         b = 8'($urandom);
         if (q.size() < (1 << FIFO_AW)) q.push_back(b);
         sendRxFrame(b, 1'b0, 1'b0, 1'b0, 1'b1, 8);
         if (i == 7) begin
            checkOutput("ovr_full8", 32'(rx_fifo_full), 32'(1));
            checkOutput("ovr_count8", 32'(rx_fifo_count), 32'(8));
            checkOutput("ovr_none_yet", 32'(rx_overrun), 32'(0));
         end
      end
      checkOutput("ovr_set", 32'(rx_overrun), 32'(1));
      checkOutput("ovr_count9", 32'(rx_fifo_count), 32'(8));
      for (int i = 0; i < 8; i++) checkRxPop($sformatf("ovr_pop%0d", i), q[i]);
      checkOutput("udr_before", 32'(rx_underrun), 32'(0));
      rx_rden = 1'b1;
      tick(1);
      rx_rden = 1'b0;
      checkOutput("udr_pulse", 32'(rx_underrun), 32'(1));
      checkOutput("udr_count", 32'(rx_fifo_count), 32'(0));
      tick(1);
      checkOutput("udr_pulse_end", 32'(rx_underrun), 32'(0));
      pulseErrClr();
      checkOutput("ovr_cleared", 32'(rx_overrun), 32'(0));

      $display("[TB] TX FIFO fill from idle, overrun, reset mid-frame");
      baud_div = 16'd20; two_stop = 1'b0;
      ovr_seen = 0;
      for (int i = 0; i < 9; i++) begin
         sent[i]  = 8'($urandom);
         tx_wdata = sent[i];
         tx_wten  = 1'b1;
         tick(1);
         if (tx_overrun) ovr_seen++;
      end
      checkOutput("txf_no_overrun", 32'(ovr_seen), 32'(0));
      checkOutput("txf_full", 32'(tx_fifo_full), 32'(1));
      tx_wdata = 8'($urandom);
      tick(1);
      tx_wten = 1'b0;
      checkOutput("txf_overrun_pulse", 32'(tx_overrun), 32'(1));
      tick(1);
      checkOutput("txf_overrun_end", 32'(tx_overrun), 32'(0));
      tick(20);
      checkOutput("txf_data_bit0", 32'(tx), 32'(sent[0][0]));
      rst = 1'b1;
      tick(1);
      checkOutput("mid_rst_tx", 32'(tx), 32'(1));
      checkOutput("mid_rst_busy", 32'(tx_busy), 32'(0));
      checkOutput("mid_rst_txfull", 32'(tx_fifo_full), 32'(0));
      checkOutput("mid_rst_rxcount", 32'(rx_fifo_count), 32'(0));
      rst = 1'b0;
      tick(30);
      checkOutput("post_rst_idle", 32'(tx), 32'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
